// File: rtl/shift_add_sequencer.sv
// Nibble-serial 8x8 multiplier sequencer driving an external combinational 16-bit adder.
// Optional ZERO_SKIP_EN: a zero operand at start bypasses MUL and goes straight to DONE.
module shift_add_sequencer #(
    parameter int DATA_W = 8,
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PROD_W-1:0] adder_dataa,
    output logic [PROD_W-1:0] adder_datab,
    input  logic [PROD_W-1:0] adder_sum,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic              done
);

    localparam int NIB_W = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        step_q, step_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic [DATA_W-1:0] a_l, a_d;
    logic [DATA_W-1:0] b_l, b_d;

    logic [NIB_W-1:0]  na, nb;
    logic [DATA_W-1:0] pp;
    logic [3:0]        shamt;
    logic [PROD_W-1:0] pp_shifted;

    // Step bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble.
    assign na    = step_q[0] ? a_l[DATA_W-1:NIB_W] : a_l[NIB_W-1:0];
    assign nb    = step_q[1] ? b_l[DATA_W-1:NIB_W] : b_l[NIB_W-1:0];
    assign pp    = {{NIB_W{1'b0}}, na} * {{NIB_W{1'b0}}, nb};
    assign shamt = {step_q[0] & step_q[1], step_q[0] ^ step_q[1], 2'b00};
    assign pp_shifted = {{(PROD_W-DATA_W){1'b0}}, pp} << shamt;

    assign adder_dataa = (state_q == MUL) ? pp_shifted : '0;
    assign adder_datab = acc_q;
    assign product     = product_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            step_q    <= 2'd0;
            acc_q     <= '0;
            product_q <= '0;
            a_l       <= '0;
            b_l       <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            a_l       <= a_d;
            b_l       <= b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        acc_d     = acc_q;
        product_d = product_q;
        a_d       = a_l;
        b_d       = b_l;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = '0;
                    step_d = 2'd0;
`ifdef ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d = MUL;
                    end
`else
                    state_d = MUL;
`endif
                end
            end
            MUL: begin
                acc_d  = adder_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    product_d = adder_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Bench for shift_add_sequencer: arithmetic reference model, per-cycle compare, directed and random stimulus.
// Honours ZERO_SKIP_EN the same way the design does.
module tb_shift_add_sequencer;

`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif
    localparam int LAT = ZS ? 0 : 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  a, b;
    logic [15:0] adder_dataa, adder_datab, adder_sum, product;
    logic        busy, done;
    logic        chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Combinational adder that the sequencer drives.
    assign adder_sum = adder_dataa + adder_datab;

    shift_add_sequencer #(.DATA_W(8), .PROD_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .adder_dataa(adder_dataa), .adder_datab(adder_datab), .adder_sum(adder_sum),
        .product(product), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Shifted partial product of step k, straight from nibble arithmetic.
    function automatic logic [15:0] term(input logic [7:0] ma, input logic [7:0] mb, input int k);
        int ia, ib, na, nb, sh;
        ia = int'(ma);
        ib = int'(mb);
        na = ((k & 1) != 0) ? ia / 16 : ia % 16;
        nb = ((k & 2) != 0) ? ib / 16 : ib % 16;
        sh = 0;
        if ((k & 1) != 0) sh += 4;
        if ((k & 2) != 0) sh += 4;
        return 16'((na * nb) << sh);
    endfunction

    function automatic logic [15:0] psum(input logic [7:0] ma, input logic [7:0] mb, input int k);
        logic [15:0] s;
        s = '0;
        for (int j = 0; j < k; j++) s = s + term(ma, mb, j);
        return s;
    endfunction

    // Model: phase 0 idle, 1..4 multiply steps 0..3, 5 done.
    int          m_phase;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_prod, m_acc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_prod  <= '0;
            m_acc   <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_a   <= a;
                    m_b   <= b;
                    m_acc <= '0;
                    if (ZS && (a == 8'd0 || b == 8'd0)) begin
                        m_prod  <= '0;
                        m_phase <= 5;
                    end else begin
                        m_phase <= 1;
                    end
                end
                1, 2, 3: m_phase <= m_phase + 1;
                4: begin
                    m_prod  <= 16'(m_a) * 16'(m_b);
                    m_acc   <= 16'(m_a) * 16'(m_b);
                    m_phase <= 5;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 5));
            chk("product", 32'(product), 32'(m_prod));
            if (m_phase >= 1 && m_phase <= 4) begin
                chk("adder_dataa", 32'(adder_dataa), 32'(term(m_a, m_b, m_phase - 1)));
                chk("adder_datab", 32'(adder_datab), 32'(psum(m_a, m_b, m_phase - 1)));
            end else begin
                chk("adder_dataa_idle", 32'(adder_dataa), 32'd0);
                chk("adder_datab_idle", 32'(adder_datab), 32'(m_acc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic mul_run(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp_p,
                           input int exp_lat, input logic [15:0] exp_d0);
        int n;
        tick();
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        if (exp_lat == 4) chk("dataa_step0_lit", 32'(adder_dataa), 32'(exp_d0));
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("done_latency", 32'(n), 32'(exp_lat));
        chk("product_lit", 32'(product), 32'(exp_p));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #2 reset_n = 1'b0;
        #1 chk_en = 1'b1;

        chk("model_term_6x10", 32'(term(8'd6, 8'd10, 0)), 32'd60);
        chk("model_term_120x200_k3", 32'(term(8'd120, 8'd200, 3)), 32'd21504);
        chk("model_sum_120x200", 32'(psum(8'd120, 8'd200, 4)), 32'd24000);
        chk("model_sum_255x255", 32'(psum(8'd255, 8'd255, 4)), 32'd65025);

        repeat (2) @(negedge clk);
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dataa", 32'(adder_dataa), 32'd0);
        tick();
        reset_n = 1'b1;

        mul_run(8'd6,   8'd10,  16'h003C, 4, 16'd60);
        mul_run(8'd120, 8'd200, 16'h5DC0, 4, 16'd64);
        mul_run(8'd255, 8'd255, 16'hFE01, 4, 16'd225);

        // Start held high; operand change after acceptance must not matter.
        tick();
        a = 8'd150;
        b = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1 a = 8'd3;
        wait_done(n);
        chk("b2b_latency", 32'(n), 32'd4);
        chk("b2b_product", 32'(product), 32'h7530);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_second_accept", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b2_latency", 32'(n), 32'd4);
        chk("b2b2_product", 32'(product), 32'd600);

        // Asynchronous reset in the middle of step 2.
        tick();
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_product", 32'(product), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        mul_run(8'd0, 8'd77, 16'd0, LAT, 16'd0);

        // Random traffic, including zero operands, ignored starts and rare resets.
        for (int i = 0; i < 600; i++) begin
            tick();
            reset_n = ($urandom_range(0, 149) != 0);
            start   = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        end
        tick();
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
